// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave framing MOSI words to RAM and shifting RAM read data out on MISO
// Bit clock is clk; one frame carries an opcode bit followed by a 10-bit word.
module spi_slave #(
  parameter logic IDLE_MISO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       MOSI,
  input  logic       SS_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  output logic       MISO
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CHK_CMD   = 3'd1;
  localparam logic [2:0] WRITE     = 3'd2;
  localparam logic [2:0] READ_ADD  = 3'd3;
  localparam logic [2:0] READ_DATA = 3'd4;

  logic [2:0] state;
  logic [9:0] rx_shreg;
  logic [3:0] bit_cnt;
  logic       word_done;
  logic       rd_addr_flag;
  logic       tx_wait;
  logic       tx_active;
  logic [7:0] tx_shreg;
  logic [2:0] tx_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_shreg     <= '0;
      bit_cnt      <= '0;
      word_done    <= 1'b0;
      rd_addr_flag <= 1'b0;
      tx_wait      <= 1'b0;
      tx_active    <= 1'b0;
      tx_shreg     <= '0;
      tx_cnt       <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      MISO         <= IDLE_MISO;
    end else begin
      rx_valid <= 1'b0;
      // Deselect wins over everything, including a 10th bit on the same edge.
      if (state != IDLE && SS_n) begin
        state     <= IDLE;
        rx_shreg  <= '0;
        bit_cnt   <= '0;
        word_done <= 1'b0;
        tx_wait   <= 1'b0;
        tx_active <= 1'b0;
        tx_shreg  <= '0;
        tx_cnt    <= '0;
        MISO      <= IDLE_MISO;
      end else begin
        case (state)
          IDLE: begin
            if (!SS_n) state <= CHK_CMD;
          end
          CHK_CMD: begin
            if (!MOSI)             state <= WRITE;
            else if (rd_addr_flag) state <= READ_DATA;
            else                   state <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!word_done) begin
              rx_shreg <= {rx_shreg[8:0], MOSI};
              if (bit_cnt == 4'd9) begin
                bit_cnt   <= '0;
                word_done <= 1'b1;
                rx_data   <= {rx_shreg[8:0], MOSI};
                rx_valid  <= 1'b1;
                if (state == READ_ADD) rd_addr_flag <= 1'b1;
                if (state == READ_DATA) begin
                  rd_addr_flag <= 1'b0;
                  tx_wait      <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end else if (tx_wait && tx_valid) begin
              // The MSB goes out on the latch edge, the rest over the next 7 edges.
              tx_wait   <= 1'b0;
              tx_active <= 1'b1;
              tx_shreg  <= {tx_data[6:0], 1'b0};
              tx_cnt    <= '0;
              MISO      <= tx_data[7];
            end else if (tx_active) begin
              if (tx_cnt == 3'd7) begin
                tx_active <= 1'b0;
                MISO      <= IDLE_MISO;
              end else begin
                MISO     <= tx_shreg[7];
                tx_shreg <= {tx_shreg[6:0], 1'b0};
                tx_cnt   <= tx_cnt + 3'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave against a frame-level reference model
module tb_spi_slave;

  localparam logic IDLE_M = 1'b1;

  logic       clk;
  logic       rst_n;
  logic       MOSI;
  logic       SS_n;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic       MISO;

  int   checks = 0;
  int   errors = 0;
  int   rxv_cnt = 0;
  bit   m_flag = 1'b0;
  logic [9:0] m_rx = '0;

  spi_slave #(.IDLE_MISO(IDLE_M)) dut (
    .clk(clk), .rst_n(rst_n), .MOSI(MOSI), .SS_n(SS_n),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .MISO(MISO)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (rx_valid === 1'b1) rxv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from deselected idle; nsent < 10 aborts after nsent bits,
  // abort10 raises SS_n together with the 10th bit, rst_at resets mid shift-out.
  task automatic frame(input bit op, input logic [9:0] w, input int nsent,
                       input bit abort10, input bit stray, input int rst_at);
    int base;
    bit full;
    bit rd;
    logic [7:0] d;
    full = (nsent == 10) && !abort10;
    rd   = op && m_flag;
    base = rxv_cnt;
    SS_n = 1'b0; tx_valid = stray; tx_data = 8'($urandom);
    @(negedge clk);
    MOSI = op;
    @(negedge clk);
    for (int i = 0; i < nsent; i++) begin
      MOSI = w[9-i];
      if (i == 9 && abort10) SS_n = 1'b1;
      @(negedge clk);
    end
    if (!full) begin
      if (!abort10) begin
        SS_n = 1'b1;
        @(negedge clk);
      end
      check("abort_idle", 32'(dut.state), 32'd0);
      check("abort_no_valid", 32'(rx_valid), 32'd0);
    end else begin
      check("rx_valid_pulse", 32'(rx_valid), 32'd1);
      check("rx_data_word", 32'(rx_data), 32'(w));
      m_rx = w;
      if (op) m_flag = !m_flag;
      MOSI = 1'($urandom);
      @(negedge clk);
      check("rx_valid_drop", 32'(rx_valid), 32'd0);
      MOSI = 1'($urandom);
      @(negedge clk);
      if (rd) begin
        check("miso_wait", 32'(MISO), 32'(IDLE_M));
        d = 8'($urandom);
        tx_valid = 1'b1; tx_data = d;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
          if (j == rst_at) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            m_flag = 1'b0;
            m_rx = '0;
            check("rst_miso", 32'(MISO), 32'(IDLE_M));
            check("rst_rx_valid", 32'(rx_valid), 32'd0);
            check("rst_flag", 32'(dut.rd_addr_flag), 32'd0);
            break;
          end
          check("miso_bit", 32'(MISO), 32'(d[7-j]));
          tx_valid = (j == 2);
          tx_data = 8'($urandom);
          MOSI = 1'($urandom);
          @(negedge clk);
        end
        tx_valid = 1'b0;
      end
      check("miso_idle_after", 32'(MISO), 32'(IDLE_M));
    end
    SS_n = 1'b1; tx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rx_valid_count", 32'(rxv_cnt - base), full ? 32'd1 : 32'd0);
    check("rx_data_hold", 32'(rx_data), 32'(m_rx));
    check("flag", 32'(dut.rd_addr_flag), 32'(m_flag));
  endtask

  initial begin
    bit op;
    int r;
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_miso", 32'(MISO), 32'(IDLE_M));
    check("reset_flag", 32'(dut.rd_addr_flag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    tx_valid = 1'b1; tx_data = 8'h00;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    check("stray_idle_miso", 32'(MISO), 32'(IDLE_M));

    frame(1'b0, 10'h0A5, 10, 1'b0, 1'b1, -1);
    frame(1'b0, 10'h13C, 10, 1'b0, 1'b0, -1);
    frame(1'b1, 10'h207, 10, 1'b0, 1'b0, -1);
    frame(1'b1, 10'h300, 10, 1'b0, 1'b0, -1);
    frame(1'b0, 10'h155, 5, 1'b0, 1'b0, -1);
    frame(1'b1, 10'h3FF, 10, 1'b1, 1'b0, -1);

    frame(1'b1, 10'h011, 10, 1'b0, 1'b0, -1);
    frame(1'b1, 10'h322, 10, 1'b0, 1'b0, 3);
    frame(1'b1, 10'h044, 10, 1'b0, 1'b0, -1);
    check("read_add_after_reset", 32'(dut.rd_addr_flag), 32'd1);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_flag = 1'b0; m_rx = '0;
    check("reset_clears_flag", 32'(dut.rd_addr_flag), 32'd0);
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      op = 1'($urandom);
      r  = int'($urandom_range(0, 7));
      if (r == 0)      frame(op, 10'($urandom), int'($urandom_range(0, 9)), 1'b0, 1'b0, -1);
      else if (r == 1) frame(op, 10'($urandom), 10, 1'b1, 1'b0, -1);
      else             frame(op, 10'($urandom), 10, 1'b0, !op && 1'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one parameter: IDLE_MISO, default 1'b0, meaning the MISO level whenever no read byte is being shifted out.
REQ-002 The block SHALL have these ports:
- clk  input  1  system clock, also used as SPI bit clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous active-low.
- MOSI  input  1  serial data from master, MSB first.
- SS_n  input  1  slave select, active-low.
- tx_valid  input  1  RAM read-data valid, one-cycle pulse.
- tx_data  input  8  RAM read data.
- rx_data  output  10  parallel word to RAM: {cmd[1:0], payload[7:0]}.
- rx_valid  output  1  rx_data valid, one-cycle pulse.
- MISO  output  1  serial data to master, MSB first.

Function
REQ-003 The FSM SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: go to CHK_CMD when SS_n=0.
- CHK_CMD: sample MOSI as the opcode bit; it is not stored. MOSI=0 goes to WRITE. MOSI=1 with rd_addr_flag=0 goes to READ_ADD. MOSI=1 with rd_addr_flag=1 goes to READ_DATA.
REQ-004 In WRITE, READ_ADD and READ_DATA, the block SHALL shift MOSI into a 10-bit register MSB first, one bit per clk, using a 4-bit counter for 0..9.
REQ-005 On the clk edge that samples the 10th bit, the block SHALL:
- load rx_data with the full 10-bit word;
- assert rx_valid for exactly one cycle on the following cycle.
REQ-006 rx_data SHALL hold its value until the next completed word.
REQ-007 Completing a word in READ_ADD SHALL set rd_addr_flag to 1. Completing a word in READ_DATA SHALL clear it to 0. WRITE SHALL leave the flag unchanged.
REQ-008 After its word completes, the block SHALL stay in the current state, ignore MOSI and shift nothing more until SS_n=1.
REQ-009 In READ_DATA after rx_valid, the first cycle with tx_valid=1 SHALL latch tx_data. MISO SHALL then drive tx_data[7] through tx_data[0] on the next 8 consecutive cycles. After that MISO SHALL return to IDLE_MISO.
REQ-010 tx_valid outside the READ_DATA wait window SHALL be ignored. A second tx_valid during shift-out SHALL be ignored.
REQ-011 When MISO is not shifting, it SHALL equal IDLE_MISO.
REQ-012 SS_n=1 in any non-IDLE state SHALL force IDLE on the next edge and abort the frame:
- bit counter, shift register and MISO shift-out cleared;
- no rx_valid for an incomplete word;
- rd_addr_flag retained.
REQ-013 SS_n=1 on the same edge as the 10th bit SHALL abort the frame; no rx_valid and no flag change.
REQ-014 A new frame SHALL require at least one cycle of SS_n=1 (IDLE) before SS_n=0.
REQ-015 rx_valid and MISO SHALL be registered outputs.

Reset
REQ-016 On rst_n=0 at a clk edge, the block SHALL go to IDLE and set rx_data=0, rx_valid=0, MISO=IDLE_MISO, rd_addr_flag=0, counters=0 and shift registers=0.
REQ-017 Reset SHALL take priority over all inputs. Reset mid-frame or mid-shift-out SHALL discard all partial data.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Write address: SS_n=0, opcode 0, MOSI 10'b00_1010_0101 -> one rx_valid pulse, rx_data=10'h0A5, flag stays 0.
- Write data: opcode 0, MOSI 10'b01_0011_1100 -> rx_data=10'h13C, one rx_valid pulse.
- Read address then data:
  - opcode 1, 10'b10_0000_0111 -> rx_data=10'h207, flag=1.
  - next frame, opcode 1, 10'b11_0000_0000 -> rx_data=10'h300, flag=0.
  - tx_valid with tx_data=8'hC3 -> MISO=1,1,0,0,0,0,1,1 on 8 cycles, then IDLE_MISO.
- Abort: SS_n=1 after 5 bits -> IDLE next edge, no rx_valid, rx_data unchanged.
- Reset mid-shift-out (after 3 MISO bits) -> MISO=IDLE_MISO, rx_valid=0, rd_addr_flag=0; a following read frame goes to READ_ADD.
- Stray tx_valid in IDLE or WRITE -> MISO stays IDLE_MISO.
